time_counter: RTL and testbench
===============================

# time_counter

Timekeeping datapath for the digital clock; it is the receiving end of the mode state machine's control outputs. It counts seconds, minutes and hours in BCD from a 1 Hz enable and applies the state machine's seconds-reset and minute/hour increment commands. It drives per-field blanking so the field being set blinks on the 7-segment display.

## Interface
- HOURS, 24: hour modulus; legal values 24 (00–23) or 12 (00–11).
- CLK  in  1  system clock; all state changes on the rising edge.
- RESETL  in  1  asynchronous, active-low reset.
- EN1HZ  in  1  one-CLK-wide pulse, once per second, from the prescaler.
- EN2HZ  in  1  one-CLK-wide pulse, twice per second; drives the blink phase.
- sec_resetl  in  1  active-low; holds seconds at 00 while low.
- min_inc  in  1  level from the state machine; each 0→1 edge adds one minute.
- hour_inc  in  1  level; each 0→1 edge adds one hour.
- sec_onoff, min_onoff, hour_onoff  in  1 each  1 = field steady; 0 = field blinks.
- SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10  out  4 each  BCD digits (ones, tens).
- SEC_BLANK, MIN_BLANK, HOUR_BLANK  out  1 each  1 = display driver must blank the field.

## Operation
- Counter ranges:
  - Seconds: 00–59.
  - Minutes: 00–59.
  - Hours: 00–(HOURS-1).
  - Tens digits never exceed 5 (seconds/minutes) or 2 (hours). Ones digits never exceed 9.
- Seconds:
  - When sec_resetl=0, seconds load 00 every cycle. EN1HZ is ignored and no carry is generated.
  - When sec_resetl=1 and EN1HZ=1, seconds increment. At 59 they wrap to 00 and generate sec_carry for one cycle.
- Minutes:
  - min_edge = min_inc & ~min_inc_q, where min_inc_q is a register reset to 0.
  - Each cycle, minute_next = (minute + sec_carry + min_edge) mod 60.
  - min_carry = 1 when that sum reaches or crosses 60 through sec_carry only. A min_edge wrap 59→00 produces no hour carry.
  - If sec_carry and min_edge coincide at 59, the minute goes to 01 and min_carry=1.
- Hours:
  - hour_edge is detected the same way as min_edge.
  - hour_next = (hour + min_carry + hour_edge) mod HOURS. Hours have no onward carry.
- Edge-detect registers: min_inc_q and hour_inc_q. An input already high on the first cycle after reset release counts as one edge.
- Blink:
  - Register blink toggles on each EN2HZ.
  - X_BLANK = ~x_onoff & blink, for each field, combinationally from the registered blink and the input.
  - With all onoff=1, every BLANK output is 0.
- Counters are binary-to-BCD-free: the design is held as separate BCD digits with digit-wise carry. The ones digit wraps 9→0 and increments the tens digit.

## Timing
- Reset (RESETL=0, asynchronous): all digits 0, blink=0, min_inc_q=0, hour_inc_q=0, therefore all BLANK outputs 0. Counting resumes on the first rising CLK edge with RESETL=1.
- Latency:
  - Digit outputs are registered. A qualifying EN1HZ, min_inc edge or hour_inc edge sampled at edge n is visible after edge n.
  - A full carry chain 23:59:59→00:00:00 completes in that same single edge; there is no ripple delay across cycles.
- sec_resetl is sampled synchronously. Seconds read 00 after the first edge on which it is low.
- Holding min_inc or hour_inc high produces exactly one increment. A new increment needs a low cycle first.
- EN1HZ, EN2HZ, min_edge and hour_edge may all coincide in one cycle; every rule above applies simultaneously.
- BLANK outputs change in the cycle after an EN2HZ toggle edge, or combinationally with onoff.

## Test plan
- Reset and ticks:
  - Stimulus: assert RESETL=0 mid-count, then release and apply 3 EN1HZ pulses.
  - Response: all digits 0 and BLANKs 0 during reset; then SEC1=3, SEC10=0.
- Full rollover:
  - Stimulus: apply 23 hour_inc pulses, 59 min_inc pulses and 59 EN1HZ pulses to reach 23:59:59, then one EN1HZ.
  - Response: 00:00:00 after that single edge.
  - With HOURS=12, 11:59:59 rolls to 00:00:00.
- Set-mode increments:
  - Stimulus: at minute 59, one min_inc pulse.
  - Response: minute 00, hour unchanged.
  - Stimulus: min_inc held high for 5 cycles.
  - Response: +1 only.
  - Stimulus: hour_inc edge at hour 23.
  - Response: hour 00.
- Seconds reset:
  - Stimulus: at 00:00:42, hold sec_resetl=0 across 3 EN1HZ pulses, then release.
  - Response: seconds 00 throughout, minute unchanged. The next EN1HZ after release gives 01.
- Coincidence:
  - Stimulus: at 00:59:59, EN1HZ and min_inc edge in the same cycle.
  - Response: 01:01:00.
  - Stimulus: at 05:58:59, EN1HZ, min_inc edge and hour_inc edge in the same cycle.
  - Response: 06:00:00 (minute 58+1+1=60 wraps to 00; the min_edge is not a carry source, so only hour_edge adds an hour), confirming the carry-source rule.
- Blink:
  - Stimulus: min_onoff=0, others 1, with 4 EN2HZ pulses.
  - Response: MIN_BLANK alternates 1,0,1,0. SEC_BLANK and HOUR_BLANK stay 0.
  - Stimulus: set min_onoff=1.
  - Response: MIN_BLANK goes 0 immediately.

Source files
------------

// File: rtl/time_counter_if.sv
// Control and display bundle between the mode state machine, time_counter and the display driver.
interface time_counter_if;
  logic       EN1HZ;
  logic       EN2HZ;
  logic       sec_resetl;
  logic       min_inc;
  logic       hour_inc;
  logic       sec_onoff;
  logic       min_onoff;
  logic       hour_onoff;
  logic [3:0] SEC1;
  logic [3:0] SEC10;
  logic [3:0] MIN1;
  logic [3:0] MIN10;
  logic [3:0] HOUR1;
  logic [3:0] HOUR10;
  logic       SEC_BLANK;
  logic       MIN_BLANK;
  logic       HOUR_BLANK;

  // Controller / stimulus side: drives enables and commands, observes digits and blanking.
  modport master (
    output EN1HZ, EN2HZ, sec_resetl, min_inc, hour_inc,
    output sec_onoff, min_onoff, hour_onoff,
    input  SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10,
    input  SEC_BLANK, MIN_BLANK, HOUR_BLANK
  );

  // Counter side.
  modport slave (
    input  EN1HZ, EN2HZ, sec_resetl, min_inc, hour_inc,
    input  sec_onoff, min_onoff, hour_onoff,
    output SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10,
    output SEC_BLANK, MIN_BLANK, HOUR_BLANK
  );
endinterface

// File: rtl/time_counter.sv
// BCD seconds/minutes/hours counter with set-mode increments and per-field blink blanking.
module time_counter #(
  parameter int unsigned HOURS = 24
) (
  input logic           CLK,
  input logic           RESETL,
  time_counter_if.slave bus
);

  localparam int unsigned HOUR_LAST      = HOURS - 1;
  localparam logic [3:0]  HOUR_LAST_TENS = 4'(HOUR_LAST / 10);
  localparam logic [3:0]  HOUR_LAST_ONES = 4'(HOUR_LAST % 10);
  localparam logic [3:0]  SM_LAST_TENS   = 4'd5;
  localparam logic [3:0]  SM_LAST_ONES   = 4'd9;
  localparam logic [7:0]  SM_LAST        = {SM_LAST_TENS, SM_LAST_ONES};

  // Two-digit BCD increment: ones wraps 9->0 into tens, whole field wraps after its last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [3:0] last_tens,
                                         input logic [3:0] last_ones);
    logic [7:0] r;
    if (v == {last_tens, last_ones}) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic [7:0] r_hour;
  logic       r_min_inc_q;
  logic       r_hour_inc_q;
  logic       r_blink;

  logic       w_min_edge;
  logic       w_hour_edge;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic [7:0] w_sec_next;
  logic [7:0] w_min_step;
  logic [7:0] w_min_next;
  logic [7:0] w_hour_step;
  logic [7:0] w_hour_next;

  // Rising-edge detect on the set-mode increment levels.
  assign w_min_edge  = bus.min_inc  & ~r_min_inc_q;
  assign w_hour_edge = bus.hour_inc & ~r_hour_inc_q;

  // Seconds: synchronous hold-at-zero has priority; carry only on a real 59->00 tick.
  always_comb begin
    w_sec_next  = r_sec;
    w_sec_carry = 1'b0;
    if (!bus.sec_resetl) begin
      w_sec_next = 8'h00;
    end else if (bus.EN1HZ) begin
      w_sec_next  = bcd_inc(r_sec, SM_LAST_TENS, SM_LAST_ONES);
      w_sec_carry = (r_sec == SM_LAST);
    end
  end

  // Minutes: seconds carry first, then the set edge; only the seconds carry can feed hours.
  always_comb begin
    w_min_step  = r_min;
    w_min_carry = 1'b0;
    if (w_sec_carry) begin
      w_min_step  = bcd_inc(r_min, SM_LAST_TENS, SM_LAST_ONES);
      w_min_carry = (r_min == SM_LAST);
    end
    w_min_next = w_min_step;
    if (w_min_edge) begin
      w_min_next = bcd_inc(w_min_step, SM_LAST_TENS, SM_LAST_ONES);
    end
  end

  // Hours: minute carry and set edge each add one, modulo HOURS; no onward carry.
  always_comb begin
    w_hour_step = r_hour;
    if (w_min_carry) begin
      w_hour_step = bcd_inc(r_hour, HOUR_LAST_TENS, HOUR_LAST_ONES);
    end
    w_hour_next = w_hour_step;
    if (w_hour_edge) begin
      w_hour_next = bcd_inc(w_hour_step, HOUR_LAST_TENS, HOUR_LAST_ONES);
    end
  end

  // Time-of-day registers; the whole carry chain settles in one edge.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_sec  <= 8'h00;
      r_min  <= 8'h00;
      r_hour <= 8'h00;
    end else begin
      r_sec  <= w_sec_next;
      r_min  <= w_min_next;
      r_hour <= w_hour_next;
    end
  end

  // Edge-detect history; cleared so a level already high after reset counts once.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_min_inc_q  <= 1'b0;
      r_hour_inc_q <= 1'b0;
    end else begin
      r_min_inc_q  <= bus.min_inc;
      r_hour_inc_q <= bus.hour_inc;
    end
  end

  // Blink phase toggles at 2 Hz.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_blink <= 1'b0;
    end else if (bus.EN2HZ) begin
      r_blink <= ~r_blink;
    end
  end

  assign bus.SEC1   = r_sec[3:0];
  assign bus.SEC10  = r_sec[7:4];
  assign bus.MIN1   = r_min[3:0];
  assign bus.MIN10  = r_min[7:4];
  assign bus.HOUR1  = r_hour[3:0];
  assign bus.HOUR10 = r_hour[7:4];

  // Blanking follows onoff combinationally so leaving set mode un-blanks at once.
  assign bus.SEC_BLANK  = ~bus.sec_onoff  & r_blink;
  assign bus.MIN_BLANK  = ~bus.min_onoff  & r_blink;
  assign bus.HOUR_BLANK = ~bus.hour_onoff & r_blink;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a 24-hour and a 12-hour instance share the same stimulus.
module tb_time_counter;

  logic clk;
  logic rst_n;
  logic en1hz, en2hz, sec_resetl, min_inc, hour_inc;
  logic sec_onoff, min_onoff, hour_onoff;

  int n_checks = 0;
  int n_errors = 0;

  time_counter_if if24 ();
  time_counter_if if12 ();

  assign if24.EN1HZ = en1hz;      assign if12.EN1HZ = en1hz;
  assign if24.EN2HZ = en2hz;      assign if12.EN2HZ = en2hz;
  assign if24.sec_resetl = sec_resetl; assign if12.sec_resetl = sec_resetl;
  assign if24.min_inc = min_inc;  assign if12.min_inc = min_inc;
  assign if24.hour_inc = hour_inc; assign if12.hour_inc = hour_inc;
  assign if24.sec_onoff = sec_onoff;   assign if12.sec_onoff = sec_onoff;
  assign if24.min_onoff = min_onoff;   assign if12.min_onoff = min_onoff;
  assign if24.hour_onoff = hour_onoff; assign if12.hour_onoff = hour_onoff;

  time_counter #(.HOURS(24)) u_dut24 (.CLK(clk), .RESETL(rst_n), .bus(if24.slave));
  time_counter #(.HOURS(12)) u_dut12 (.CLK(clk), .RESETL(rst_n), .bus(if12.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed HH:MM:SS BCD views for compact comparisons.
  logic [23:0] t24, t12;
  logic [2:0]  blank24;
  assign t24 = {if24.HOUR10, if24.HOUR1, if24.MIN10, if24.MIN1, if24.SEC10, if24.SEC1};
  assign t12 = {if12.HOUR10, if12.HOUR1, if12.MIN10, if12.MIN1, if12.SEC10, if12.SEC1};
  assign blank24 = {if24.HOUR_BLANK, if24.MIN_BLANK, if24.SEC_BLANK};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en1hz = 0; en2hz = 0; min_inc = 0; hour_inc = 0; sec_resetl = 1;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      en1hz = 1; tick(); en1hz = 0;
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      min_inc = 1; tick(); min_inc = 0; tick();
    end
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      hour_inc = 1; tick(); hour_inc = 0; tick();
    end
  endtask

  initial begin
    rst_n = 0;
    en1hz = 0; en2hz = 0; sec_resetl = 1; min_inc = 0; hour_inc = 0;
    sec_onoff = 1; min_onoff = 1; hour_onoff = 1;
    #12;
    check("reset_time", 32'(t24), 32'h000000);
    check("reset_blank", 32'(blank24), 32'h0);
    rst_n = 1;
    tick();

    // Count, then reset asynchronously mid-count.
    pulse_sec(5);
    check("count5", 32'(t24), 32'h000005);
    #2 rst_n = 0;
    #1;
    check("async_reset_time", 32'(t24), 32'h000000);
    check("async_reset_blank", 32'(blank24), 32'h0);
    tick();
    rst_n = 1;
    pulse_sec(3);
    check("three_ticks", 32'(t24), 32'h000003);

    // Full rollover on both hour moduli.
    apply_reset();
    pulse_hour(23);
    pulse_min(59);
    pulse_sec(59);
    check("pre_roll24", 32'(t24), 32'h235959);
    check("pre_roll12", 32'(t12), 32'h115959);
    pulse_sec(1);
    check("roll24", 32'(t24), 32'h000000);
    check("roll12", 32'(t12), 32'h000000);

    // Set-mode increments.
    pulse_min(59);
    check("min59", 32'(t24), 32'h005900);
    pulse_min(1);
    check("min_wrap_no_carry", 32'(t24), 32'h000000);
    min_inc = 1;
    for (int i = 0; i < 5; i++) tick();
    min_inc = 0; tick();
    check("min_held", 32'(t24), 32'h000100);
    pulse_hour(23);
    check("hour23", 32'(t24), 32'h230100);
    pulse_hour(1);
    check("hour_wrap", 32'(t24), 32'h000100);

    // Seconds hold at zero.
    apply_reset();
    pulse_sec(42);
    check("sec42", 32'(t24), 32'h000042);
    sec_resetl = 0;
    tick();
    check("sec_hold0", 32'(t24), 32'h000000);
    for (int i = 0; i < 3; i++) begin
      pulse_sec(1);
      check("sec_hold_tick", 32'(t24), 32'h000000);
    end
    sec_resetl = 1;
    tick();
    check("sec_release", 32'(t24), 32'h000000);
    pulse_sec(1);
    check("sec_after_release", 32'(t24), 32'h000001);

    // Coincident tick and set edges.
    apply_reset();
    pulse_min(59);
    pulse_sec(59);
    check("pre_coinc1", 32'(t24), 32'h005959);
    en1hz = 1; min_inc = 1; tick(); en1hz = 0; min_inc = 0; tick();
    check("coinc1", 32'(t24), 32'h010100);

    apply_reset();
    pulse_hour(5);
    pulse_min(58);
    pulse_sec(59);
    check("pre_coinc2", 32'(t24), 32'h055859);
    en1hz = 1; min_inc = 1; hour_inc = 1; tick();
    en1hz = 0; min_inc = 0; hour_inc = 0; tick();
    check("coinc2", 32'(t24), 32'h060000);

    // Blink of the minute field only.
    min_onoff = 0;
    #1;
    check("blink_idle", 32'(blank24), 32'h0);
    for (int i = 0; i < 4; i++) begin
      en2hz = 1; tick(); en2hz = 0;
      check("blink_min", 32'(blank24), (i % 2 == 0) ? 32'h2 : 32'h0);
    end
    en2hz = 1; tick(); en2hz = 0;
    check("blink_on", 32'(blank24), 32'h2);
    min_onoff = 1;
    #1;
    check("blink_off_now", 32'(blank24), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
